// File: rtl/enc256_iter_pkg.sv
// Shared definitions for the iterative AES-256 encryptor.
// Holds the FSM state codes, round constants, the S-box and the GF(2^8) and key schedule helpers.
package enc256_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  AES256_NR     = 4'd14;
  localparam logic [31:0] AES_RCON_INIT = 32'h01000000;

  // Entry 0 is the leftmost byte, so SBOX[x] is the forward S-box of x.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Produces the next eight schedule words from the current eight; words 4..7 use
  // SubWord without rotation or rcon, as AES-256 requires.
  function automatic logic [255:0] key_exp256(input logic [255:0] k, input logic [31:0] rcon);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    {w0, w1, w2, w3, w4, w5, w6, w7} = k;
    n0 = w0 ^ sub_word({w7[23:0], w7[31:24]}) ^ rcon;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    n4 = w4 ^ sub_word(n3);
    n5 = w5 ^ n4;
    n6 = w6 ^ n5;
    n7 = w7 ^ n6;
    return {n0, n1, n2, n3, n4, n5, n6, n7};
  endfunction

endpackage

// File: rtl/enc256_iter_if.sv
// Block-in / block-out bus of the AES-256 encryptor.
// Each direction is strict valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and data stable until then, and ready never depends on valid.
interface enc256_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic [255:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  modport master (
    output in_valid, in, key, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, key, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/enc256_iter_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
// Byte 0 of the state is in bits [127:120]; bytes run down columns.
module enc256_iter_round
  import enc256_iter_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [0:15][7:0] s_in;
  logic [0:15][7:0] sb;
  logic [0:15][7:0] sr;
  logic [0:15][7:0] mc;

  assign s_in = state_in;

  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign sb[b] = sbox(s_in[b]);
  end

  // Row r rotates left by r columns.
  assign sr = {sb[0],  sb[5],  sb[10], sb[15],
               sb[4],  sb[9],  sb[14], sb[3],
               sb[8],  sb[13], sb[2],  sb[7],
               sb[12], sb[1],  sb[6],  sb[11]};

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign state_out = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/enc256_iter.sv
// Iterative AES-256 encryptor: one round per clock, key schedule expanded on the fly.
// Holds the FSM, the state register, the 8-word key window, the round constant and the round counter.
module enc256_iter
  import enc256_iter_pkg::*;
#(
  parameter bit ZERO_OUT_IDLE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  enc256_iter_if.slave io,
  output state_t       dbg_state
);

  state_t       state;
  logic [127:0] st_q;
  logic [255:0] kreg;
  logic [31:0]  rcon_q;
  logic [3:0]   rnd_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [127:0] rk;
  logic [127:0] round_out;
  logic [255:0] kexp;
  logic         last;

  // Odd rounds use the upper-half words (w4..w7 of the window), even rounds the lower half.
  assign rk   = rnd_q[0] ? kreg[127:0] : kreg[255:128];
  assign last = (rnd_q == AES256_NR);
  assign kexp = key_exp256(kreg, rcon_q);

  enc256_iter_round u_round (
    .state_in  (st_q),
    .rk        (rk),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      st_q        <= '0;
      kreg        <= '0;
      rcon_q      <= AES_RCON_INIT;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            st_q       <= io.in ^ io.key[255:128];
            kreg       <= io.key;
            rcon_q     <= AES_RCON_INIT;
            rnd_q      <= 4'd1;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          st_q <= round_out;
          // The window advances after each odd round: seven expansions over rounds 1..13.
          if (rnd_q[0]) begin
            kreg   <= kexp;
            rcon_q <= rcon_q << 1;
          end
          if (last) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out       = (ZERO_OUT_IDLE && !out_valid_q) ? 128'h0 : st_q;
  assign dbg_state    = state;

endmodule
